// File: rtl/norm_shift_seq.sv
// norm_shift_seq: multi-cycle normalization shifter feeding shift correction.
// Shifts a WIDTH-bit mantissa by up to STEP positions per cycle until the
// requested amount is consumed, then holds the result under a valid/ready
// handshake.
// Optional feature macro: NORMSHIFTSEQ_RSHIFT_EN adds right-shift support
// (InRight) and a Sticky output collecting the bits lost off bit 0.
module norm_shift_seq #(
  parameter int WIDTH = 128,
  parameter int LOGW  = 7,
  parameter int STEP  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InMant,
  input  logic [LOGW-1:0]  InShamt,
`ifdef NORMSHIFTSEQ_RSHIFT_EN
  input  logic             InRight,
  output logic             Sticky,
`endif
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Shifted,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateE;

  // One extra bit so STEP == WIDTH still fits.
  localparam logic [LOGW:0] STEP_W = (LOGW+1)'(STEP);

  stateE            state;
  logic [WIDTH-1:0] work;
  logic [LOGW-1:0]  remaining;
  logic [LOGW:0]    remExt;
  logic [LOGW:0]    k;
  logic             lastStep;
  logic             accept;
  logic [WIDTH-1:0] workNext;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
  logic             right;
  logic             stickyReg;
  logic             lostBits;
`endif

  assign InReady  = ~Flush & ((state == IDLE) | ((state == DONE) & OutReady));
  assign accept   = InValid & InReady;
  assign OutValid = (state == DONE);
  assign Busy     = (state != IDLE);
  assign Shifted  = work;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
  assign Sticky   = stickyReg;
`endif

  // Per-cycle shift amount: whatever is left, capped at STEP.
  always_comb begin
    remExt   = {1'b0, remaining};
    lastStep = (remExt <= STEP_W);
    k        = lastStep ? remExt : STEP_W;
  end

  // Next working value for one SHIFT cycle; vacated bits are zero-filled.
  always_comb begin
    workNext = work << k;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
    lostBits = 1'b0;
    if (right) begin
      workNext = work >> k;
      lostBits = |(work & ~({WIDTH{1'b1}} << k));
    end
`endif
  end

  // Control FSM and datapath registers; Flush only steers the state back
  // to IDLE and leaves the working register untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
      right     <= 1'b0;
      stickyReg <= 1'b0;
`endif
    end else if (Flush) begin
      state <= IDLE;
    end else if (accept) begin
      work      <= InMant;
      remaining <= InShamt;
      state     <= (InShamt == '0) ? DONE : SHIFT;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
      right     <= InRight;
      stickyReg <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          work      <= workNext;
          remaining <= remaining - k[LOGW-1:0];
`ifdef NORMSHIFTSEQ_RSHIFT_EN
          stickyReg <= stickyReg | lostBits;
`endif
          if (lastStep) state <= DONE;
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_shift_seq.sv
// Scoreboard bench for norm_shift_seq: stimulus pushes hand-computed results
// with their expected first-valid cycle; a negedge monitor pops and compares.
module tb_norm_shift_seq;
  localparam int WIDTH = 128;
  localparam int LOGW  = 7;
  localparam int STEP  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             InValid = 1'b0;
  logic             Flush = 1'b0;
  logic             OutReady = 1'b1;
  logic             InReady, OutValid, Busy;
  logic [WIDTH-1:0] InMant = '0;
  logic [WIDTH-1:0] Shifted;
  logic [LOGW-1:0]  InShamt = '0;
`ifdef NORMSHIFTSEQ_RSHIFT_EN
  logic             InRight = 1'b0;
  logic             Sticky;
`endif

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             stk;
    int               due;
  } expT;

  expT  sb[$];
  int   cyc = 0;
  int   nVec = 0;
  int   nMis = 0;
  logic prevValid = 1'b0;
  logic prevHs = 1'b0;

  norm_shift_seq #(.WIDTH(WIDTH), .LOGW(LOGW), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .InMant(InMant), .InShamt(InShamt),
`ifdef NORMSHIFTSEQ_RSHIFT_EN
    .InRight(InRight), .Sticky(Sticky),
`endif
    .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .Shifted(Shifted), .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE cycle is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset && OutValid) begin
      if (sb.size() == 0) begin
        nVec++; nMis++;
        $display("FAIL spurious OutValid at cycle %0d: got Shifted=%h want no output", cyc, Shifted);
      end else begin
        chk("Shifted", Shifted, sb[0].val);
        if (!prevValid || prevHs) chk("latency", WIDTH'(cyc), WIDTH'(sb[0].due));
`ifdef NORMSHIFTSEQ_RSHIFT_EN
        chk("Sticky", WIDTH'(Sticky), WIDTH'(sb[0].stk));
`endif
        if (OutReady) void'(sb.pop_front());
      end
    end
    prevValid = reset && OutValid;
    prevHs    = reset && OutValid && OutReady;
  end

  // Present one operand (called at posedge+1); returns at posedge+1 after accept.
  task automatic issue(input logic [WIDTH-1:0] m, input int sh, input logic rt,
                       input logic track, input logic [WIDTH-1:0] expVal,
                       input logic expStk);
    int n = 0;
    InValid = 1'b1;
    InMant  = m;
    InShamt = LOGW'(sh);
`ifdef NORMSHIFTSEQ_RSHIFT_EN
    InRight = rt;
`endif
    @(negedge clk);
    while (!InReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    nVec++;
    if (!InReady) begin
      nMis++;
      $display("FAIL accept timeout: got InReady=0 want 1");
    end else if (track) begin
      sb.push_back('{val: expVal, stk: expStk, due: cyc + (sh + STEP - 1) / STEP + 1});
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    InMant  = ~m;          // must not leak in after the accept
    InShamt = ~LOGW'(sh);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    nVec++;
    if (sb.size() != 0) begin
      nMis++;
      $display("FAIL drain: got %0d pending outputs want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst OutValid", WIDTH'(OutValid), '0);
    chk("rst Busy", WIDTH'(Busy), '0);
    chk("rst InReady", WIDTH'(InReady), WIDTH'(1));
    chk("rst Shifted", Shifted, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Max shift: 8 SHIFT cycles, result in cycle 9
    issue(128'h1, 127, 1'b0, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    @(negedge clk);
    chk("maxshift Busy", WIDTH'(Busy), WIDTH'(1));
    chk("maxshift OutValid early", WIDTH'(OutValid), '0);
    drain();

    // Zero shift, then assorted amounts around the STEP boundary
    issue(128'h1234, 0, 1'b0, 1'b1, 128'h1234, 1'b0);
    drain();
    issue(128'hDEAD_BEEF, 5, 1'b0, 1'b1, 128'h1B_D5B7_DDE0, 1'b0);
    issue(128'hDEAD_BEEF, 16, 1'b0, 1'b1, 128'hDEAD_BEEF_0000, 1'b0);
    issue(128'hDEAD_BEEF, 17, 1'b0, 1'b1, 128'h1_BD5B_7DDE_0000, 1'b0);
    issue(128'h0123_4567_89AB_CDEF, 64, 1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_0000_0000_0000_0000, 1'b0);
    issue({WIDTH{1'b1}}, 100, 1'b0, 1'b1, 128'hFFFF_FFF0_0000_0000_0000_0000_0000_0000, 1'b0);
    issue(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, 1'b0, 1'b1, 128'h2, 1'b0);
    drain();

    // Backpressure in DONE, then back-to-back accept
    OutReady = 1'b0;
    issue(128'hABCD, 3, 1'b0, 1'b1, 128'h5_5E68, 1'b0);
    begin
      int n = 0;
      while (!OutValid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp reached DONE", WIDTH'(OutValid), WIDTH'(1));
    for (int i = 0; i < 5; i++) begin
      chk("bp InReady", WIDTH'(InReady), '0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    OutReady = 1'b1;
    issue(128'h55, 16, 1'b0, 1'b1, 128'h55_0000, 1'b0);
    drain();

    // Flush in the third SHIFT cycle of a 100-bit shift
    issue(128'hFFFF, 100, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    Flush = 1'b1;
    @(negedge clk);
    chk("flush InReady", WIDTH'(InReady), '0);
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    chk("flush Busy", WIDTH'(Busy), '0);
    chk("flush OutValid", WIDTH'(OutValid), '0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    issue(128'h3, 33, 1'b0, 1'b1, 128'h6_0000_0000, 1'b0);
    drain();

    // Reset in cycle 4 of a 64-bit shift
    issue(128'hF0F0, 64, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("pre-reset Busy", WIDTH'(Busy), WIDTH'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst OutValid", WIDTH'(OutValid), '0);
    chk("midrst Shifted", Shifted, '0);
    chk("midrst InReady", WIDTH'(InReady), WIDTH'(1));
    chk("midrst Busy", WIDTH'(Busy), '0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    issue(128'h80, 120, 1'b0, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    drain();

`ifdef NORMSHIFTSEQ_RSHIFT_EN
    // Right shifts with sticky collection
    issue(128'hFF, 4, 1'b1, 1'b1, 128'h0F, 1'b1);
    issue(128'hF0, 4, 1'b1, 1'b1, 128'h0F, 1'b0);
    issue(128'h8000_0000_0000_0000_0000_0000_0000_0001, 20, 1'b1, 1'b1,
          128'h0000_0800_0000_0000_0000_0000_0000_0000, 1'b1);
    drain();
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
